// File: rtl/benes_route_scheduler.sv
// Owns a Benes network for one requester at a time: round-robin arbitration,
// configuration load, beat streaming, then a fixed drain while the pipeline empties.
module benes_route_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int SEL_W    = 16,
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ*SEL_W-1:0] i_req_sel,
    input  logic [NUM_REQ*LEN_W-1:0] i_req_len,
    input  logic                     i_beat_ready,
    input  logic                     i_flush,
    output logic                     o_cfg_valid,
    output logic [SEL_W-1:0]         o_select,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic                     o_beat_en,
    output logic                     o_done,
    output logic [ID_W-1:0]          o_done_id
);

    // state  | meaning
    // IDLE   | arbitrating, network unowned
    // LOAD   | config applied, accept pulse to the winner
    // STREAM | beats move while i_beat_ready
    // DRAIN  | PIPE_LAT cycles for in-flight beats to exit
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q;
    logic [ID_W-1:0]     grant_q;
    logic [ID_W-1:0]     arb_idx;
    logic [ID_W-1:0]     arb_cand;
    logic [ID_W-1:0]     next_ptr;
    logic                arb_found;
    logic [SEL_W-1:0]    sel_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W:0]      beat_cnt_q;
    logic [7:0]          drain_cnt_q;
    logic [NUM_REQ-1:0]  grant_oh;
    logic                beat_en;
    logic                last_beat;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_cand = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!arb_found && i_req_valid[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    assign grant_oh  = NUM_REQ'(1) << grant_q;
    assign next_ptr  = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + ID_W'(1);
    assign beat_en   = (state_q == S_STREAM) && i_beat_ready && !i_flush;
    // Counter is one bit wider than len so a full 2^LEN_W-beat burst never wraps.
    assign last_beat = beat_en && (beat_cnt_q == {1'b0, len_q});
    assign o_beat_en = beat_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        o_req_ready = '0;
        o_cfg_valid = 1'b0;
        o_select    = '0;
        o_grant     = '0;
        o_done      = 1'b0;
        o_done_id   = '0;
        case (state_q)
            S_IDLE:   if (arb_found) state_d = S_LOAD;
            S_LOAD: begin
                state_d     = S_STREAM;
                o_req_ready = grant_oh;
            end
            S_STREAM: if (i_flush || last_beat) state_d = S_DRAIN;
            S_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d   = S_IDLE;
                    o_done    = 1'b1;
                    o_done_id = grant_q;
                end
            end
            default:  state_d = S_IDLE;
        endcase
        if (state_q != S_IDLE) begin
            o_cfg_valid = 1'b1;
            o_select    = sel_q;
            o_grant     = grant_oh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            sel_q       <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arb_found) begin
                        grant_q <= arb_idx;
                        sel_q   <= i_req_sel[arb_idx*SEL_W +: SEL_W];
                        len_q   <= i_req_len[arb_idx*LEN_W +: LEN_W];
                    end
                end
                S_LOAD:   beat_cnt_q <= '0;
                S_STREAM: begin
                    if (beat_en) beat_cnt_q <= beat_cnt_q + (LEN_W+1)'(1);
                    if (i_flush || last_beat) drain_cnt_q <= 8'(PIPE_LAT - 1);
                end
                S_DRAIN: begin
                    if (drain_cnt_q != '0) drain_cnt_q <= drain_cnt_q - 8'd1;
                    else                   rr_ptr_q    <= next_ptr;
                end
                default: ;
            endcase
        end
    end

endmodule
